// File: rtl/bsr_pkg.sv
// bsr_pkg: shared mode encoding and chain-length helper for the boundary-scan register
package bsr_pkg;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'b00,
        MODE_EXTEST = 2'b01,
        MODE_HIGHZ  = 2'b10
    } bsr_mode_e;

    function automatic int chain_len(input int width, input int num_groups);
        return width + num_groups;
    endfunction

endpackage

// File: rtl/bsr_scan_cell.sv
// bsr_scan_cell: one boundary-scan cell, capture/shift stage feeding an update stage
module bsr_scan_cell (
    input  logic clk,
    input  logic rst,
    input  logic rst_val,
    input  logic capture_dr,
    input  logic shift_dr,
    input  logic update_en,
    input  logic pi,
    input  logic si,
    output logic so,
    output logic uo
);

    logic sh_q, sh_d;
    logic up_q, up_d;

    always_comb begin
        sh_d = capture_dr ? pi : shift_dr ? si : sh_q;
        up_d = update_en ? sh_q : up_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q <= 1'b0;
            up_q <= rst_val;
        end else begin
            sh_q <= sh_d;
            up_q <= up_d;
        end
    end

    assign so = sh_q;
    assign uo = up_q;

endmodule

// File: rtl/bsr_chain.sv
// bsr_chain: boundary-scan register of WIDTH data cells plus NUM_GROUPS output-enable cells.
// Define BSR_LEN_CHECK_EN to gate updates on an exact shift count and expose update_err.
module bsr_chain
    import bsr_pkg::*;
#(
    parameter int                 WIDTH      = 32,
    parameter int                 NUM_GROUPS = 1,
    parameter logic [WIDTH-1:0]   SAFE_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  capture_dr,
    input  logic                  shift_dr,
    input  logic                  update_dr,
    input  logic [1:0]            mode,
    input  logic                  tdi,
    output logic                  tdo,
    input  logic [WIDTH-1:0]      parallel_in,
    output logic [WIDTH-1:0]      parallel_out,
    input  logic [NUM_GROUPS-1:0] func_oe,
    output logic [NUM_GROUPS-1:0] oe
`ifdef BSR_LEN_CHECK_EN
    ,
    output logic                  update_err
`endif
);

    localparam int L = chain_len(WIDTH, NUM_GROUPS);

    logic [L-1:0] cap_vec, rst_vec, si_vec, sr, upd;
    logic         update_en;

    assign cap_vec = {func_oe, parallel_in};
    assign rst_vec = {{NUM_GROUPS{1'b0}}, SAFE_VALUE};
    assign si_vec  = {tdi, sr[L-1:1]};

    genvar i;
    generate
        for (i = 0; i < L; i++) begin : g_cell
            bsr_scan_cell u_cell (
                .clk        (clk),
                .rst        (rst),
                .rst_val    (rst_vec[i]),
                .capture_dr (capture_dr),
                .shift_dr   (shift_dr),
                .update_en  (update_en),
                .pi         (cap_vec[i]),
                .si         (si_vec[i]),
                .so         (sr[i]),
                .uo         (upd[i])
            );
        end
    endgenerate

`ifdef BSR_LEN_CHECK_EN
    localparam int             CW      = $clog2(L + 1);
    localparam logic [CW-1:0]  CNT_MAX = '1;
    localparam logic [CW-1:0]  CNT_LEN = CW'(L);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          len_ok;

    // Capture takes priority so a fresh scan always starts with a clean error flag.
    always_comb begin
        len_ok = (cnt_q == CNT_LEN);
        cnt_d  = capture_dr ? '0 : (shift_dr && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
        err_d  = capture_dr ? 1'b0 : (update_dr && !len_ok) ? 1'b1 : err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign update_en  = update_dr && len_ok;
    assign update_err = err_q;
`else
    assign update_en = update_dr;
`endif

    // Reserved mode 11 falls through to the functional path.
    always_comb begin
        parallel_out = (mode == MODE_EXTEST || mode == MODE_HIGHZ) ? upd[WIDTH-1:0] : parallel_in;
        oe           = (mode == MODE_EXTEST) ? upd[L-1:WIDTH] :
                       (mode == MODE_HIGHZ)  ? '0 : func_oe;
    end

    assign tdo = sr[0];

endmodule

// File: tb/tb_bsr_chain.sv
// tb_bsr_chain: directed checks of bsr_chain at WIDTH=8, NUM_GROUPS=2, SAFE_VALUE=0.
// Build with BSR_LEN_CHECK_EN defined to also exercise the shift-length guard.
module tb_bsr_chain;

    logic       clk = 1'b0;
    logic       rst, capture_dr, shift_dr, update_dr, tdi, tdo;
    logic [1:0] mode, func_oe, oe;
    logic [7:0] parallel_in, parallel_out;
`ifdef BSR_LEN_CHECK_EN
    logic       update_err;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bsr_chain #(.WIDTH(8), .NUM_GROUPS(2), .SAFE_VALUE(8'h00)) dut (
        .clk          (clk),
        .rst          (rst),
        .capture_dr   (capture_dr),
        .shift_dr     (shift_dr),
        .update_dr    (update_dr),
        .mode         (mode),
        .tdi          (tdi),
        .tdo          (tdo),
        .parallel_in  (parallel_in),
        .parallel_out (parallel_out),
        .func_oe      (func_oe),
        .oe           (oe)
`ifdef BSR_LEN_CHECK_EN
        ,
        .update_err   (update_err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse(input logic c, input logic s, input logic u, input logic d);
        capture_dr = c;
        shift_dr   = s;
        update_dr  = u;
        tdi        = d;
        @(posedge clk);
        #1;
        capture_dr = 1'b0;
        shift_dr   = 1'b0;
        update_dr  = 1'b0;
        tdi        = 1'b0;
    endtask

    // dout[k] is tdo seen before shift k; din[k] is the tdi bit of shift k.
    task automatic scan(input int n, input logic [9:0] din, output logic [9:0] dout);
        dout = '0;
        for (int k = 0; k < n; k++) begin
            dout[k] = tdo;
            pulse(1'b0, 1'b1, 1'b0, din[k]);
        end
    endtask

    logic [9:0] dout;
    logic [9:0] exp_a5;

    initial begin
        rst = 1'b1; capture_dr = 0; shift_dr = 0; update_dr = 0; tdi = 0;
        mode = 2'b01; parallel_in = 8'h5A; func_oe = 2'b11;
        #3;
        check("rst_pout", parallel_out, 8'h00);
        check("rst_oe", oe, 2'b00);
        check("rst_tdo", tdo, 1'b0);
`ifdef BSR_LEN_CHECK_EN
        check("rst_err", update_err, 1'b0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("rel_pout", parallel_out, 8'h00);
        check("rel_oe", oe, 2'b00);

        mode = 2'b00; parallel_in = 8'hA5; func_oe = 2'b10;
        #1;
        check("norm_pout", parallel_out, 8'hA5);
        check("norm_oe", oe, 2'b10);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        scan(10, 10'h000, dout);
        exp_a5 = 10'b10_1010_0101;
        for (int k = 0; k < 10; k++) check($sformatf("tdo_seq%0d", k), dout[k], exp_a5[k]);
        check("tdo_drained", tdo, 1'b0);

        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        scan(10, 10'h13C, dout);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        mode = 2'b01; #1;
        check("extest_pout", parallel_out, 8'h3C);
        check("extest_oe", oe, 2'b01);
        mode = 2'b10; #1;
        check("highz_pout", parallel_out, 8'h3C);
        check("highz_oe", oe, 2'b00);
        mode = 2'b11; parallel_in = 8'h96; func_oe = 2'b10; #1;
        check("rsvd_pout", parallel_out, 8'h96);
        check("rsvd_oe", oe, 2'b10);
        mode = 2'b01;
        repeat (3) @(posedge clk);
        #1;
        check("hold_pout", parallel_out, 8'h3C);
        check("hold_oe", oe, 2'b01);

        parallel_in = 8'hFF; func_oe = 2'b11;
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        scan(10, 10'h000, dout);
        check("cap_wins", dout, 10'h3FF);

`ifndef BSR_LEN_CHECK_EN
        parallel_in = 8'h5A; func_oe = 2'b10;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b1, 1'b1);
        check("upd_pre_pout", parallel_out, 8'h5A);
        check("upd_pre_oe", oe, 2'b10);
        check("upd_pre_tdo", tdo, 1'b1);
`else
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        scan(9, 10'h2C3, dout);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("short_pout", parallel_out, 8'h3C);
        check("short_oe", oe, 2'b01);
        check("short_err", update_err, 1'b1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("cap_clr_err", update_err, 1'b0);
        scan(10, 10'h2C3, dout);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("full_pout", parallel_out, 8'hC3);
        check("full_oe", oe, 2'b10);
        check("full_err", update_err, 1'b0);
        scan(1, 10'h000, dout);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("long_pout", parallel_out, 8'hC3);
        check("long_err", update_err, 1'b1);
`endif

        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        scan(5, 10'h3FF, dout);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_pout", parallel_out, 8'h00);
        check("mid_rst_oe", oe, 2'b00);
        check("mid_rst_tdo", tdo, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        scan(10, 10'h1E7, dout);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("post_rst_pout", parallel_out, 8'hE7);
        check("post_rst_oe", oe, 2'b01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bsr_chain.md
BSR_CHAIN -- requirements
Module: bsr_chain

Interface
REQ-001 SHALL have parameter WIDTH, default 32, number of data boundary cells (>=1).
REQ-002 SHALL have parameter NUM_GROUPS, default 1, number of output-enable control cells (>=1).
REQ-003 SHALL have parameter SAFE_VALUE, WIDTH bits, default all-0, reset value of the data update register.
REQ-004 SHALL have ports: clk in 1 JTAG TCK, sole clock; rst in 1 reset, asynchronous, active-high.
REQ-005 SHALL have ports: capture_dr in 1, shift_dr in 1, update_dr in 1, single-cycle enables sampled at posedge clk.
REQ-006 SHALL have ports: mode in 2 cell mode; tdi in 1; tdo out 1.
REQ-007 SHALL have ports: parallel_in in WIDTH; parallel_out out WIDTH; func_oe in NUM_GROUPS; oe out NUM_GROUPS.
REQ-008 SHALL have port update_err out 1, present only when BSR_LEN_CHECK_EN is defined.

Function
REQ-009 Chain length L = WIDTH+NUM_GROUPS; bit 0 (tdo end) = data cell 0; bits WIDTH..L-1 = control cells 0..NUM_GROUPS-1; tdi enters bit L-1.
REQ-010 capture_dr: shift register loads {func_oe, parallel_in} on the edge.
REQ-011 shift_dr: shift register shifts one bit toward bit 0, tdi into bit L-1.
REQ-012 capture_dr and shift_dr both high: capture wins, no shift.
REQ-013 tdo = shift register bit 0, combinational from the flop; changes only on a clk edge.
REQ-014 update_dr: update register loads the shift register value held before that edge; simultaneous shift/capture does not affect the value loaded.
REQ-015 mode 00 NORMAL: parallel_out=parallel_in, oe=func_oe.
REQ-016 mode 01 EXTEST: parallel_out=data update bits, oe=control update bits.
REQ-017 mode 10 HIGHZ: parallel_out=data update bits, oe=all-0.
REQ-018 mode 11 is reserved and behaves as NORMAL.
REQ-019 Mode muxing is combinational; a mode change takes effect without a clock edge.
REQ-020 No enable asserted: shift and update registers hold.

Reset
REQ-021 rst high, asynchronously: shift register all-0; data update register SAFE_VALUE; control update register all-0.
REQ-022 Reset mid-shift discards partial data; the first edge after release obeys REQ-010..REQ-014.
REQ-023 When rst is released with mode=EXTEST: oe=0 and parallel_out=SAFE_VALUE.

Configuration
REQ-024 Macro BSR_LEN_CHECK_EN defined: a saturating shift counter clears on capture_dr and increments on each shift_dr edge.
REQ-025 With BSR_LEN_CHECK_EN, update_dr with counter != L is suppressed (update register holds) and sets sticky update_err.
REQ-026 With BSR_LEN_CHECK_EN, update_err clears on capture_dr or rst; an update with counter == L proceeds and leaves update_err unchanged.
REQ-027 Counter width: $clog2(L+1); it saturates at its maximum value.
REQ-028 Macro BSR_LEN_CHECK_EN undefined: no counter; update_dr is unconditional; the update_err port is absent.

Structure
REQ-029 Package bsr_pkg SHALL hold: mode enum (NORMAL=00, EXTEST=01, HIGHZ=10) and a chain-length function of WIDTH and NUM_GROUPS.
REQ-030 Sub-module bsr_scan_cell SHALL implement one capture/shift/update cell with a reset value input.
REQ-031 bsr_chain SHALL instantiate L bsr_scan_cell instances plus the output muxing and the optional counter.

Verification (WIDTH=8, NUM_GROUPS=2, L=10, SAFE_VALUE=8'h00)
REQ-032 Assert rst with mode=01 -> parallel_out=8'h00, oe=2'b00, tdo=0, update_err=0.
REQ-033 Capture parallel_in=8'hA5, func_oe=2'b10; then 10 shifts with tdi=0 -> tdo=1,0,1,0,0,1,0,1,0,1, seen in that order one bit per edge after capture.
REQ-034 Shift {oe=2'b01, data=8'h3C} LSB first (10 shifts); update; mode=01 -> parallel_out=8'h3C, oe=2'b01; then mode=10 -> oe=2'b00, parallel_out=8'h3C.
REQ-035 capture_dr and shift_dr high on the same edge with parallel_in=8'hFF, func_oe=2'b11 -> shift register = 10'h3FF, no shift.
REQ-036 With BSR_LEN_CHECK_EN: capture, 9 shifts, update -> update register unchanged, update_err=1; capture, 10 shifts, update -> new value loaded, update_err=0.
REQ-037 rst pulsed after 5 of 10 shifts -> update register returns to SAFE_VALUE; a later full 10-shift sequence and update yields correct parallel_out.
